// File: rtl/pid_pkg.sv
// -----------------------------------------------------------------------------
// pid_pkg
// Shared definitions for the pid_host register-load / iterate driver:
//   - pid_host_state_t : FSM state encoding used by pid_host
//   - PID_ADDR_KP/KI   : pid core register addresses for the gain registers
//   - PID_D_WIDTH/PID_Q_BITS : default data width and gain fractional bits
// -----------------------------------------------------------------------------
package pid_pkg;

    localparam int PID_D_WIDTH = 16;
    localparam int PID_Q_BITS  = 13;

    localparam int PID_ADDR_KP = 0;
    localparam int PID_ADDR_KI = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_KP = 3'd1,
        ST_WR_KI = 3'd2,
        ST_READY = 3'd3,
        ST_RUN   = 3'd4
    } pid_host_state_t;

endpackage

// File: rtl/pid_plant_acc.sv
// -----------------------------------------------------------------------------
// pid_plant_acc
// Integrating plant model: on each rising edge of pid_out_valid (while enabled)
// adds pid_out into the signed measurement and pulses sample_valid for one
// cycle alongside the new value.
//
// Build option: PID_HOST_SAT_EN defined -> the sum saturates to the signed
// D_WIDTH range; undefined -> two's-complement wrap.
//
// Ports:
//   clk, rstb        clock, asynchronous active-low reset
//   enable           accept updates (host in READY or RUN)
//   pid_out_valid    valid from pid core (level or pulse; edge detected here)
//   pid_out          signed control output from pid core
//   measurement      signed plant state
//   sample_valid     one-cycle pulse when measurement updates
// -----------------------------------------------------------------------------
module pid_plant_acc #(
    parameter int D_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      enable,
    input  logic                      pid_out_valid,
    input  logic signed [D_WIDTH-1:0] pid_out,
    output logic signed [D_WIDTH-1:0] measurement,
    output logic                      sample_valid
);

    logic valid_q;
    logic rise;

    function automatic logic signed [D_WIDTH-1:0] plant_sum(
        input logic signed [D_WIDTH-1:0] a,
        input logic signed [D_WIDTH-1:0] b
    );
`ifdef PID_HOST_SAT_EN
        logic signed [D_WIDTH:0] s;
        s = {a[D_WIDTH-1], a} + {b[D_WIDTH-1], b};
        // Sign bit and next bit disagree only on overflow; clamp toward the sign.
        if (s[D_WIDTH] != s[D_WIDTH-1]) begin
            return s[D_WIDTH] ? {1'b1, {(D_WIDTH-1){1'b0}}}
                              : {1'b0, {(D_WIDTH-1){1'b1}}};
        end
        return s[D_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // A valid held high for several cycles yields a single update.
    assign rise = pid_out_valid & ~valid_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            valid_q      <= 1'b0;
            measurement  <= '0;
            sample_valid <= 1'b0;
        end else begin
            valid_q      <= pid_out_valid;
            sample_valid <= 1'b0;
            if (rise && enable) begin
                measurement  <= plant_sum(measurement, pid_out);
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pid_host.sv
// -----------------------------------------------------------------------------
// pid_host
// Host-side driver for the pid core: on cfg_start loads Kp then Ki through the
// active-low register write port, then asserts iterate enable while run is
// high. Closes the loop with an integrating plant (pid_plant_acc).
//
// Build option: PID_HOST_SAT_EN (see pid_plant_acc) selects saturating plant.
//
// Ports:
//   clk, rstb            clock, asynchronous active-low reset
//   cfg_start            pulse: latch kp_in/ki_in and (re)load gains
//   kp_in, ki_in         gains, Q(D_WIDTH-Q_BITS).Q_BITS
//   run                  level: request closed-loop iteration
//   pid_write_enable     active-low write strobe to pid
//   pid_reg_addr/data    register address/data to pid
//   pid_iterate_enable   iterate enable to pid
//   pid_out, pid_out_valid  control output and valid from pid
//   measurement          signed plant state fed back to pid
//   sample_valid         pulse when measurement updates
//   cfg_done             gains loaded (READY or RUN)
// -----------------------------------------------------------------------------
module pid_host
    import pid_pkg::*;
#(
    parameter int D_WIDTH = PID_D_WIDTH,
    parameter int Q_BITS  = PID_Q_BITS
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      cfg_start,
    input  logic [D_WIDTH-1:0]        kp_in,
    input  logic [D_WIDTH-1:0]        ki_in,
    input  logic                      run,
    output logic                      pid_write_enable,
    output logic [D_WIDTH-1:0]        pid_reg_addr,
    output logic [D_WIDTH-1:0]        pid_reg_data,
    output logic                      pid_iterate_enable,
    input  logic signed [D_WIDTH-1:0] pid_out,
    input  logic                      pid_out_valid,
    output logic signed [D_WIDTH-1:0] measurement,
    output logic                      sample_valid,
    output logic                      cfg_done
);

    // Gains must leave at least one integer bit (the sign).
    if (Q_BITS < 0 || Q_BITS >= D_WIDTH) begin : g_bad_q_bits
        $error("pid_host: Q_BITS must be in [0, D_WIDTH-1]");
    end

    pid_host_state_t state, state_next;
    logic [D_WIDTH-1:0] kp_q, ki_q;
    logic               cfg_accept;
    logic               plant_en;

    // cfg_start is only honoured outside the write sequence, so latched gains
    // stay stable for both write cycles.
    assign cfg_accept = cfg_start &&
                        (state == ST_IDLE || state == ST_READY || state == ST_RUN);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Gain latches are pure data; reset is not needed since they only reach
    // the outputs during WR_* states.
    always_ff @(posedge clk) begin
        if (cfg_accept) begin
            kp_q <= kp_in;
            ki_q <= ki_in;
        end
    end

    // Outputs decode the registered state, so an asynchronous reset forces
    // them (including the write strobe) back to idle values immediately.
    always_comb begin
        state_next         = state;
        pid_write_enable   = 1'b1;
        pid_reg_addr       = '0;
        pid_reg_data       = '0;
        pid_iterate_enable = 1'b0;
        cfg_done           = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cfg_start) state_next = ST_WR_KP;
            end
            ST_WR_KP: begin
                pid_write_enable = 1'b0;
                pid_reg_addr     = D_WIDTH'(PID_ADDR_KP);
                pid_reg_data     = kp_q;
                state_next       = ST_WR_KI;
            end
            ST_WR_KI: begin
                pid_write_enable = 1'b0;
                pid_reg_addr     = D_WIDTH'(PID_ADDR_KI);
                pid_reg_data     = ki_q;
                state_next       = ST_READY;
            end
            ST_READY: begin
                cfg_done = 1'b1;
                if (cfg_start)  state_next = ST_WR_KP;
                else if (run)   state_next = ST_RUN;
            end
            ST_RUN: begin
                cfg_done           = 1'b1;
                pid_iterate_enable = 1'b1;
                if (cfg_start)  state_next = ST_WR_KP;
                else if (!run)  state_next = ST_READY;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // READY included so a valid landing as iteration drops is still taken.
    assign plant_en = (state == ST_READY) || (state == ST_RUN);

    pid_plant_acc #(
        .D_WIDTH (D_WIDTH)
    ) u_plant (
        .clk           (clk),
        .rstb          (rstb),
        .enable        (plant_en),
        .pid_out_valid (pid_out_valid),
        .pid_out       (pid_out),
        .measurement   (measurement),
        .sample_valid  (sample_valid)
    );

endmodule
